// File: rtl/uart_cmd_assembler.sv
// Assembles 2-byte UART frames (command code, sensor address) into commands
// offered over valid/ready, with timeout/address/overrun error reporting.
module uart_cmd_assembler #(
  parameter int TIMEOUT_CLKS = 5_000_000,
  parameter int NUM_ADDR     = 32
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Cmd_Ready,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd_Code,
  output logic [7:0] o_Cmd_Addr,
  output logic       o_Busy,
  output logic       o_Err_Timeout,
  output logic       o_Err_Addr,
  output logic       o_Err_Overrun,
  output logic [7:0] o_Err_Count
);

  localparam int TIMER_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [8:0]         ADDR_LIMIT = 9'(NUM_ADDR);

  typedef enum logic [1:0] {
    s_WAIT_CMD  = 2'd0,
    s_WAIT_ADDR = 2'd1,
    s_ISSUE     = 2'd2
  } state_t;

  state_t               state_r;
  logic [TIMER_W-1:0]   timer_r;

  logic addr_ok_s;
  logic err_timeout_s;
  logic err_addr_s;
  logic err_overrun_s;
  logic err_any_s;

  // At most one of these can be true in a given cycle since each belongs to a distinct state/DV case.
  assign addr_ok_s     = ({1'b0, i_Rx_Byte} < ADDR_LIMIT);
  assign err_timeout_s = (state_r == s_WAIT_ADDR) && !i_Rx_DV && (timer_r == TIMER_LAST);
  assign err_addr_s    = (state_r == s_WAIT_ADDR) && i_Rx_DV && !addr_ok_s;
  assign err_overrun_s = (state_r == s_ISSUE) && i_Rx_DV;
  assign err_any_s     = err_timeout_s | err_addr_s | err_overrun_s;

  // Frame sequencer, error pulses and saturating error counter.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r       <= s_WAIT_CMD;
      timer_r       <= {TIMER_W{1'b0}};
      o_Cmd_Valid   <= 1'b0;
      o_Cmd_Code    <= 8'h00;
      o_Cmd_Addr    <= 8'h00;
      o_Busy        <= 1'b0;
      o_Err_Timeout <= 1'b0;
      o_Err_Addr    <= 1'b0;
      o_Err_Overrun <= 1'b0;
      o_Err_Count   <= 8'h00;
    end else begin
      o_Err_Timeout <= err_timeout_s;
      o_Err_Addr    <= err_addr_s;
      o_Err_Overrun <= err_overrun_s;
      if (err_any_s && (o_Err_Count != 8'hFF)) begin
        o_Err_Count <= o_Err_Count + 8'd1;
      end else begin
        o_Err_Count <= o_Err_Count;
      end

      case (state_r)
        s_WAIT_CMD: begin
          if (i_Rx_DV) begin
            o_Cmd_Code <= i_Rx_Byte;
            timer_r    <= {TIMER_W{1'b0}};
            state_r    <= s_WAIT_ADDR;
            o_Busy     <= 1'b1;
          end else begin
            state_r <= s_WAIT_CMD;
          end
        end
        s_WAIT_ADDR: begin
          // A DV on the expiry cycle takes priority over the timeout.
          if (i_Rx_DV) begin
            if (addr_ok_s) begin
              o_Cmd_Addr  <= i_Rx_Byte;
              o_Cmd_Valid <= 1'b1;
              state_r     <= s_ISSUE;
            end else begin
              state_r <= s_WAIT_CMD;
              o_Busy  <= 1'b0;
            end
          end else if (timer_r == TIMER_LAST) begin
            state_r <= s_WAIT_CMD;
            o_Busy  <= 1'b0;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        s_ISSUE: begin
          if (o_Cmd_Valid && i_Cmd_Ready) begin
            o_Cmd_Valid <= 1'b0;
            state_r     <= s_WAIT_CMD;
            o_Busy      <= 1'b0;
          end else begin
            state_r <= s_ISSUE;
          end
        end
        default: begin
          state_r     <= s_WAIT_CMD;
          o_Cmd_Valid <= 1'b0;
          o_Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Randomised and directed bench for uart_cmd_assembler, checked every cycle
// against a frame-level model (edges-since-command age, pending-command flag).
module tb_uart_cmd_assembler;

  localparam int TIMEOUT = 100;
  localparam int NADDR   = 32;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       ready;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_addr;
  logic       busy;
  logic       err_to;
  logic       err_ad;
  logic       err_ov;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // model state
  bit  m_open;
  bit  m_pending;
  int  m_age;
  int  m_code;
  int  m_addr;
  bit  m_to, m_ad, m_ov;
  int  m_cnt;

  uart_cmd_assembler #(.TIMEOUT_CLKS(TIMEOUT), .NUM_ADDR(NADDR)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .i_Cmd_Ready  (ready),
    .o_Cmd_Valid  (cmd_valid),
    .o_Cmd_Code   (cmd_code),
    .o_Cmd_Addr   (cmd_addr),
    .o_Busy       (busy),
    .o_Err_Timeout(err_to),
    .o_Err_Addr   (err_ad),
    .o_Err_Overrun(err_ov),
    .o_Err_Count  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_open = 0; m_pending = 0; m_age = 0; m_code = 0; m_addr = 0;
      m_to = 0; m_ad = 0; m_ov = 0; m_cnt = 0;
      return;
    end
    m_to = 0; m_ad = 0; m_ov = 0;
    if (m_pending) begin
      if (rx_dv) m_ov = 1;
      if (ready) m_pending = 0;
    end else if (m_open) begin
      m_age++;
      if (rx_dv) begin
        m_open = 0;
        if (int'(rx_byte) < NADDR) begin
          m_addr = int'(rx_byte);
          m_pending = 1;
        end else begin
          m_ad = 1;
        end
      end else if (m_age == TIMEOUT) begin
        m_open = 0;
        m_to = 1;
      end
    end else if (rx_dv) begin
      m_open = 1;
      m_age  = 0;
      m_code = int'(rx_byte);
    end
    if (m_to || m_ad || m_ov) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("valid",   32'(cmd_valid), 32'(m_pending));
      chk("code",    32'(cmd_code),  32'(m_code));
      chk("addr",    32'(cmd_addr),  32'(m_addr));
      chk("busy",    32'(busy),      32'(m_open || m_pending));
      chk("err_to",  32'(err_to),    32'(m_to));
      chk("err_ad",  32'(err_ad),    32'(m_ad));
      chk("err_ov",  32'(err_ov),    32'(m_ov));
      chk("err_cnt", 32'(err_cnt),   32'(m_cnt));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Call at a negedge; byte is sampled on the next posedge, returns at the following negedge.
  task automatic drive_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic idle_rand(input int n);
    for (int i = 0; i < n; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
  endtask

  int ov_seen;

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_cnt",   32'(err_cnt),   32'd0);
    rst = 1'b0;
    idle(2);

    // 1: frame with a gap below the timeout, ready high
    drive_byte(8'h01);
    idle(59);
    drive_byte(8'h05);
    chk("t1_valid", 32'(cmd_valid), 32'd1);
    chk("t1_code",  32'(cmd_code),  32'h01);
    chk("t1_addr",  32'(cmd_addr),  32'h05);
    idle(1);
    chk("t1_valid_drop", 32'(cmd_valid), 32'd0);
    chk("t1_cnt",        32'(err_cnt),   32'd0);

    // 3: out-of-range address then boundary address
    drive_byte(8'h03);
    drive_byte(8'h20);
    chk("t3_err_ad", 32'(err_ad),    32'd1);
    chk("t3_valid",  32'(cmd_valid), 32'd0);
    chk("t3_cnt",    32'(err_cnt),   32'd1);
    idle(1);
    chk("t3_err_ad_pulse", 32'(err_ad), 32'd0);
    drive_byte(8'h03);
    drive_byte(8'h1F);
    chk("t3_valid_ok", 32'(cmd_valid), 32'd1);
    chk("t3_addr_ok",  32'(cmd_addr),  32'h1F);
    idle(2);

    // 2: backpressure with an overrun byte
    ready = 1'b0;
    drive_byte(8'h02);
    drive_byte(8'h07);
    ov_seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        rx_dv = 1'b1; rx_byte = 8'hAA;
      end else begin
        rx_dv = 1'b0; rx_byte = 8'h00;
      end
      @(negedge clk);
      if (err_ov) ov_seen++;
    end
    rx_dv = 1'b0;
    chk("t2_ov_pulses", 32'(ov_seen),   32'd1);
    chk("t2_valid",     32'(cmd_valid), 32'd1);
    chk("t2_code",      32'(cmd_code),  32'h02);
    chk("t2_addr",      32'(cmd_addr),  32'h07);
    ready = 1'b1;
    idle(1);
    chk("t2_accepted", 32'(cmd_valid), 32'd0);
    chk("t2_cnt",      32'(err_cnt),   32'd2);
    idle(2);

    // 4: timeout after exactly TIMEOUT edges, next byte treated as a command
    drive_byte(8'h04);
    idle(TIMEOUT - 1);
    chk("t4_no_to_early", 32'(err_to), 32'd0);
    idle(1);
    chk("t4_to",   32'(err_to),  32'd1);
    chk("t4_busy", 32'(busy),    32'd0);
    chk("t4_cnt",  32'(err_cnt), 32'd3);
    drive_byte(8'h09);
    chk("t4_busy_cmd", 32'(busy),      32'd1);
    chk("t4_novalid",  32'(cmd_valid), 32'd0);
    chk("t4_code",     32'(cmd_code),  32'h09);
    drive_byte(8'h01);
    idle(2);

    // 5: address DV on the expiry edge
    drive_byte(8'h0C);
    idle(TIMEOUT - 1);
    drive_byte(8'h11);
    chk("t5_valid", 32'(cmd_valid), 32'd1);
    chk("t5_no_to", 32'(err_to),    32'd0);
    chk("t5_addr",  32'(cmd_addr),  32'h11);
    idle(2);
    for (int i = 0; i < 300; i++) begin
      drive_byte(8'h10);
      drive_byte(8'h80);
    end
    idle(1);
    chk("t5_sat", 32'(err_cnt), 32'd255);

    // 6: asynchronous reset mid-frame
    drive_byte(8'h33);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy",  32'(busy),     32'd0);
    chk("t6_code",  32'(cmd_code), 32'd0);
    chk("t6_cnt",   32'(err_cnt),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    drive_byte(8'h06);
    drive_byte(8'h02);
    chk("t6_valid", 32'(cmd_valid), 32'd1);
    chk("t6_code2", 32'(cmd_code),  32'h06);
    chk("t6_addr2", 32'(cmd_addr),  32'h02);
    idle(2);

    // randomised traffic
    for (int n = 0; n < 500; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) drive_byte(8'($urandom_range(0, 255)));
      else                           drive_byte(8'($urandom_range(0, NADDR - 1)));
      if ($urandom_range(0, 19) == 0) idle_rand($urandom_range(90, 110));
      else                            idle_rand($urandom_range(0, 6));
    end
    idle_rand(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
